// File: rtl/mul_div_seq.sv
// Sequential radix-2 multiply / restoring divide unit producing a HI/LO pair
// over WIDTH iterations, with ULA-compatible N/Z flags taken from LO.
module mul_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             Nflag,
    output logic             Zflag
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] work_hi_r;
    logic [WIDTH-1:0] work_lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             div_zero_r;

    logic             accept_s;
    logic             last_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] quo_sh_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [WIDTH-1:0] div_quo_s;

    assign accept_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign last_s   = (cnt_r == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero divisor skips iteration and lands directly in DONE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    if (!op) begin
                        state_nxt_s = S_MUL;
                    end else if (b == {WIDTH{1'b0}}) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_DIV;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done can be registered
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            S_MUL, S_DIV: busy_nxt_s = 1'b1;
            S_DONE:       done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // One shift-add step; the carry out of the WIDTH+1-bit sum shifts into acc_hi
    always_comb begin
        if (work_lo_r[0]) begin
            mul_sum_s = {1'b0, work_hi_r} + {1'b0, a_r};
        end else begin
            mul_sum_s = {1'b0, work_hi_r};
        end
        mul_hi_s = mul_sum_s[WIDTH:1];
        mul_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
    end

    // One restoring-division step; the remainder is widened by one bit for the compare
    always_comb begin
        rem_sh_s = {work_hi_r, work_lo_r[WIDTH-1]};
        quo_sh_s = {work_lo_r[WIDTH-2:0], 1'b0};
        if (rem_sh_s >= {1'b0, b_r}) begin
            div_rem_s = WIDTH'(rem_sh_s - {1'b0, b_r});
            div_quo_s = quo_sh_s | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            div_rem_s = rem_sh_s[WIDTH-1:0];
            div_quo_s = quo_sh_s;
        end
    end

    // Datapath: operand capture, iteration, and result load on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CW{1'b0}};
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            work_hi_r  <= {WIDTH{1'b0}};
            work_lo_r  <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            div_zero_r <= 1'b0;
        end else if (accept_s) begin
            a_r        <= a;
            b_r        <= b;
            cnt_r      <= {CW{1'b0}};
            div_zero_r <= 1'b0;
            work_hi_r  <= {WIDTH{1'b0}};
            if (!op) begin
                work_lo_r <= b;
            end else begin
                work_lo_r <= a;
                if (b == {WIDTH{1'b0}}) begin
                    hi_r       <= a;
                    lo_r       <= {WIDTH{1'b1}};
                    div_zero_r <= 1'b1;
                end
            end
        end else if (state_r == S_MUL) begin
            work_hi_r <= mul_hi_s;
            work_lo_r <= mul_lo_s;
            cnt_r     <= cnt_r + CW'(1);
            if (last_s) begin
                hi_r <= mul_hi_s;
                lo_r <= mul_lo_s;
            end
        end else if (state_r == S_DIV) begin
            work_hi_r <= div_rem_s;
            work_lo_r <= div_quo_s;
            cnt_r     <= cnt_r + CW'(1);
            if (last_s) begin
                hi_r <= div_rem_s;
                lo_r <= div_quo_s;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign div_zero = div_zero_r;
    assign Nflag    = lo_r[WIDTH-1];
    assign Zflag    = (lo_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_mul_div_seq.sv
// Randomised self-checking bench for mul_div_seq against an arithmetic reference.
module tb_mul_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, div_zero, Nflag, Zflag;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mul_div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero),
        .Nflag(Nflag), .Zflag(Zflag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic
    task automatic model(input logic o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] eh, output logic [31:0] el, output logic ez);
        logic [63:0] p;
        if (!o) begin
            p  = 64'(av) * 64'(bv);
            eh = p[63:32];
            el = p[31:0];
            ez = 1'b0;
        end else if (bv == 32'd0) begin
            eh = av;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
        end else begin
            eh = av % bv;
            el = av / bv;
            ez = 1'b0;
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 in the done cycle (chain) or one cycle later
    task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                          input int poke, input bit chain);
        logic [31:0] eh, el;
        logic ez;
        int n;
        bit hold_ok, busy_ok, dz;
        model(o, av, bv, eh, el, ez);
        dz = o && (bv == 32'd0);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
        n = 0; hold_ok = 1'b1; busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (hi !== exp_hi || lo !== exp_lo || div_zero !== 1'b0) hold_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == poke) begin
                start = 1'b1; a = $urandom; b = $urandom; op = ~o;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("latency", 64'(n), dz ? 64'd0 : 64'd32);
        check("hold", 64'(hold_ok), 64'd1);
        check("busy_iter", 64'(busy_ok), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("hi", 64'(hi), 64'(eh));
        check("lo", 64'(lo), 64'(el));
        check("div_zero", 64'(div_zero), 64'(ez));
        check("nflag", 64'(Nflag), 64'(el[31]));
        check("zflag", 64'(Zflag), 64'(el == 32'd0));
        exp_hi = eh;
        exp_lo = el;
        if (!chain) begin
            @(posedge clk); #1;
            check("done_pulse", 64'(done), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        bit saw_done;
        logic o;
        logic [31:0] av, bv;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_n", 64'(Nflag), 64'd0);
        check("rst_z", 64'(Zflag), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 32'd7, 32'd6, -1, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(1'b1, 32'd100, 32'd7, -1, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'd1, -1, 1'b0);
        run_op(1'b1, 32'd5, 32'd0, -1, 1'b0);
        run_op(1'b0, 32'd3, 32'd0, -1, 1'b0);
        run_op(1'b0, 32'd123456, 32'd789, 10, 1'b1);
        run_op(1'b1, 32'hFFFF_FFFF, 32'h0001_0000, -1, 1'b1);
        run_op(1'b1, 32'd0, 32'd9, -1, 1'b0);
        run_op(1'b1, 32'd3, 32'hFFFF_FFFF, -1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            o  = 1'($urandom_range(0, 1));
            av = $urandom;
            bv = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) bv = bv >> $urandom_range(0, 31);
            run_op(o, av, bv, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1,
                   1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;

        // Abort a divide at cycle 15 with an asynchronous reset
        start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_z", 64'(Zflag), 64'd1);
        check("arst_dz", 64'(div_zero), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("no_done_after_rst", 64'(saw_done), 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        run_op(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
